// File: rtl/sd_bd_fetch.sv
// BD fetch stage: reads 4x16-bit buffer descriptors from the descriptor store, launches one
// block transfer per BD and returns the slot with a 2-cycle a_cmp pulse.
//
// state   | meaning
// IDLE    | waiting for a pending BD (free_bd != BD_FREE_MAX, no abort)
// RD_REQ  | one-cycle BD word read strobe, arms ack timeout
// RD_WAIT | waiting for ack_i_s, captures word
// START   | launch transfer (or skip on abort)
// XFER    | waiting for xfer_done
// CMP1    | first a_cmp cycle
// CMP2    | second a_cmp cycle
// FATAL   | ack timeout, terminal until reset
module sd_bd_fetch #(
  parameter int                     BD_WIDTH    = 8,
  parameter logic [BD_WIDTH-1:0]    BD_FREE_MAX = 8'd64,
  parameter int                     ACK_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BD_WIDTH-1:0] free_bd,
  output logic                re_s,
  input  logic                ack_i_s,
  input  logic [15:0]         dat_in_s,
  output logic                a_cmp,
  output logic                start_tx,
  output logic [31:0]         sys_adr,
  output logic [31:0]         blk_adr,
  input  logic                xfer_done,
  input  logic                xfer_err,
  input  logic                abort,
  output logic                busy,
  output logic                bd_err,
  input  logic                err_clr,
  output logic                fatal
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, START, XFER, CMP1, CMP2, FATAL
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    wcnt_q, wcnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [31:0]   sys_q, sys_d;
  logic [31:0]   blk_q, blk_d;
  logic          err_q, err_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      wcnt_q  <= 2'd0;
      tmr_q   <= '0;
      sys_q   <= 32'd0;
      blk_q   <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tmr_q   <= tmr_d;
      sys_q   <= sys_d;
      blk_q   <= blk_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    tmr_d   = tmr_q;
    sys_d   = sys_q;
    blk_d   = blk_q;
    // a set later in this block overrides the clear
    err_d   = err_q & ~err_clr;
    unique case (state_q)
      IDLE: begin
        if (free_bd != BD_FREE_MAX && !abort) state_d = RD_REQ;
      end
      RD_REQ: begin
        tmr_d   = TMR_LOAD;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (ack_i_s) begin
          wcnt_d = wcnt_q + 2'd1;
          unique case (wcnt_q)
            2'd0: sys_d[31:16] = dat_in_s;
            2'd1: sys_d[15:0]  = dat_in_s;
            2'd2: blk_d[31:16] = dat_in_s;
            2'd3: blk_d[15:0]  = dat_in_s;
          endcase
          state_d = (wcnt_q == 2'd3) ? START : RD_REQ;
        end else if (tmr_q == '0) begin
          state_d = FATAL;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      START: begin
        if (abort) begin
          err_d   = 1'b1;
          state_d = CMP1;
        end else begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (xfer_done) begin
          if (xfer_err) err_d = 1'b1;
          state_d = CMP1;
        end
      end
      CMP1:    state_d = CMP2;
      CMP2:    state_d = IDLE;
      FATAL:   state_d = FATAL;
      default: state_d = IDLE;
    endcase
  end

  assign re_s     = (state_q == RD_REQ);
  assign start_tx = (state_q == START) && !abort;
  assign a_cmp    = (state_q == CMP1) || (state_q == CMP2);
  assign busy     = (state_q != IDLE);
  assign fatal    = (state_q == FATAL);
  assign bd_err   = err_q;
  assign sys_adr  = sys_q;
  assign blk_adr  = blk_q;

endmodule

// File: tb/tb_sd_bd_fetch.sv
// Directed self-checking bench for sd_bd_fetch; DUT outputs sampled on the falling edge.
module tb_sd_bd_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  free_bd;
  logic        re_s;
  logic        ack_i_s;
  logic [15:0] dat_in_s;
  logic        a_cmp;
  logic        start_tx;
  logic [31:0] sys_adr;
  logic [31:0] blk_adr;
  logic        xfer_done;
  logic        xfer_err;
  logic        abort;
  logic        busy;
  logic        bd_err;
  logic        err_clr;
  logic        fatal;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt_re   = 0;
  int cnt_st   = 0;
  int cnt_cmp  = 0;
  int b_re, b_st, b_cmp;

  always #5 clk = ~clk;

  sd_bd_fetch dut (
    .clk(clk), .rst(rst), .free_bd(free_bd), .re_s(re_s), .ack_i_s(ack_i_s),
    .dat_in_s(dat_in_s), .a_cmp(a_cmp), .start_tx(start_tx), .sys_adr(sys_adr),
    .blk_adr(blk_adr), .xfer_done(xfer_done), .xfer_err(xfer_err), .abort(abort),
    .busy(busy), .bd_err(bd_err), .err_clr(err_clr), .fatal(fatal)
  );

  always @(posedge clk) begin
    if (re_s === 1'b1)     cnt_re  <= cnt_re + 1;
    if (start_tx === 1'b1) cnt_st  <= cnt_st + 1;
    if (a_cmp === 1'b1)    cnt_cmp <= cnt_cmp + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_re(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (re_s === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, " re_s seen"}, {31'd0, found}, 32'd1);
  endtask

  task automatic serve(input logic [15:0] w, input string tag);
    wait_re(tag);
    @(negedge clk);
    chk({tag, " re_s gap"}, {31'd0, re_s}, 32'd0);
    ack_i_s  = 1'b1;
    dat_in_s = w;
    @(negedge clk);
    ack_i_s  = 1'b0;
    dat_in_s = 16'h0000;
  endtask

  task automatic fetch4(input logic [15:0] w0, input logic [15:0] w1,
                        input logic [15:0] w2, input logic [15:0] w3, input string tag);
    serve(w0, {tag, " w0"});
    serve(w1, {tag, " w1"});
    serve(w2, {tag, " w2"});
    serve(w3, {tag, " w3"});
  endtask

  task automatic snap();
    b_re  = cnt_re;
    b_st  = cnt_st;
    b_cmp = cnt_cmp;
  endtask

  initial begin
    rst = 1'b0; free_bd = 8'd64; ack_i_s = 1'b0; dat_in_s = 16'h0;
    xfer_done = 1'b0; xfer_err = 1'b0; abort = 1'b0; err_clr = 1'b0;

    // reset
    @(negedge clk); @(negedge clk);
    chk("rst re_s", {31'd0, re_s}, 0);
    chk("rst a_cmp", {31'd0, a_cmp}, 0);
    chk("rst start_tx", {31'd0, start_tx}, 0);
    chk("rst busy", {31'd0, busy}, 0);
    chk("rst bd_err", {31'd0, bd_err}, 0);
    chk("rst fatal", {31'd0, fatal}, 0);
    chk("rst sys_adr", sys_adr, 0);
    chk("rst blk_adr", blk_adr, 0);
    rst = 1'b1;
    snap();
    repeat (6) @(negedge clk);
    chk("idle64 re_s count", cnt_re - b_re, 0);
    chk("idle64 busy", {31'd0, busy}, 0);

    // single BD
    snap();
    free_bd = 8'd63;
    @(negedge clk);
    chk("bd1 re_s after idle", {31'd0, re_s}, 1);
    fetch4(16'h1234, 16'h5678, 16'h0000, 16'h0010, "bd1");
    chk("bd1 start_tx", {31'd0, start_tx}, 1);
    chk("bd1 sys_adr", sys_adr, 32'h1234_5678);
    chk("bd1 blk_adr", blk_adr, 32'h0000_0010);
    chk("bd1 busy", {31'd0, busy}, 1);
    @(negedge clk);
    chk("bd1 start_tx one cycle", {31'd0, start_tx}, 0);
    @(negedge clk);
    chk("bd1 xfer a_cmp", {31'd0, a_cmp}, 0);
    xfer_done = 1'b1;
    @(negedge clk);
    xfer_done = 1'b0;
    chk("bd1 cmp1 a_cmp", {31'd0, a_cmp}, 1);
    chk("bd1 bd_err", {31'd0, bd_err}, 0);
    free_bd = 8'd64;
    @(negedge clk);
    chk("bd1 cmp2 a_cmp", {31'd0, a_cmp}, 1);
    chk("bd1 stable sys_adr", sys_adr, 32'h1234_5678);
    @(negedge clk);
    chk("bd1 idle a_cmp", {31'd0, a_cmp}, 0);
    chk("bd1 idle busy", {31'd0, busy}, 0);
    repeat (4) @(negedge clk);
    chk("bd1 re_s count", cnt_re - b_re, 4);
    chk("bd1 start_tx count", cnt_st - b_st, 1);
    chk("bd1 a_cmp cycles", cnt_cmp - b_cmp, 2);

    // back-to-back BDs, second ends with xfer_err
    snap();
    free_bd = 8'd62;
    fetch4(16'h0001, 16'h0002, 16'h0003, 16'h0004, "b2b1");
    chk("b2b1 sys_adr", sys_adr, 32'h0001_0002);
    @(negedge clk);
    xfer_done = 1'b1;
    @(negedge clk);
    xfer_done = 1'b0;
    free_bd = 8'd63;
    @(negedge clk);
    chk("b2b1 cmp2 re_s", {31'd0, re_s}, 0);
    @(negedge clk);
    chk("b2b gap re_s", {31'd0, re_s}, 0);
    chk("b2b gap a_cmp", {31'd0, a_cmp}, 0);
    chk("b2b gap busy", {31'd0, busy}, 0);
    @(negedge clk);
    chk("b2b2 re_s", {31'd0, re_s}, 1);
    fetch4(16'hDEAD, 16'hBEEF, 16'hCAFE, 16'h0001, "b2b2");
    chk("b2b2 sys_adr", sys_adr, 32'hDEAD_BEEF);
    chk("b2b2 blk_adr", blk_adr, 32'hCAFE_0001);
    @(negedge clk);
    xfer_done = 1'b1;
    xfer_err  = 1'b1;
    @(negedge clk);
    xfer_done = 1'b0;
    xfer_err  = 1'b0;
    chk("b2b2 err bd_err", {31'd0, bd_err}, 1);
    chk("b2b2 err a_cmp", {31'd0, a_cmp}, 1);
    free_bd = 8'd64;
    repeat (4) @(negedge clk);
    chk("b2b re_s count", cnt_re - b_re, 8);
    chk("b2b start_tx count", cnt_st - b_st, 2);
    chk("b2b a_cmp cycles", cnt_cmp - b_cmp, 4);
    chk("b2b bd_err sticky", {31'd0, bd_err}, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr clears", {31'd0, bd_err}, 0);

    // abort during word 1
    snap();
    free_bd = 8'd63;
    serve(16'h1111, "abt w0");
    abort = 1'b1;
    serve(16'h2222, "abt w1");
    serve(16'h3333, "abt w2");
    serve(16'h4444, "abt w3");
    chk("abt no start_tx", {31'd0, start_tx}, 0);
    chk("abt busy", {31'd0, busy}, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("abt cmp1 a_cmp", {31'd0, a_cmp}, 1);
    chk("abt set beats clr", {31'd0, bd_err}, 1);
    @(negedge clk);
    chk("abt cmp2 a_cmp", {31'd0, a_cmp}, 1);
    repeat (6) @(negedge clk);
    chk("abt held idle busy", {31'd0, busy}, 0);
    chk("abt re_s count", cnt_re - b_re, 4);
    chk("abt start_tx count", cnt_st - b_st, 0);
    chk("abt a_cmp cycles", cnt_cmp - b_cmp, 2);

    // ack timeout on second word
    abort = 1'b0;
    serve(16'h5555, "tmo w0");
    wait_re("tmo w1");
    repeat (16) @(negedge clk);
    chk("tmo not yet fatal", {31'd0, fatal}, 0);
    @(negedge clk);
    chk("tmo fatal", {31'd0, fatal}, 1);
    chk("tmo busy", {31'd0, busy}, 1);
    snap();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    repeat (10) @(negedge clk);
    chk("tmo fatal sticky", {31'd0, fatal}, 1);
    chk("tmo no re_s", cnt_re - b_re, 0);
    chk("tmo no a_cmp", cnt_cmp - b_cmp, 0);

    // reset clears fatal, then reset in the middle of a transfer
    rst = 1'b0;
    free_bd = 8'd64;
    @(negedge clk);
    chk("rst clears fatal", {31'd0, fatal}, 0);
    chk("rst clears bd_err", {31'd0, bd_err}, 0);
    rst = 1'b1;
    free_bd = 8'd63;
    fetch4(16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0, "mid");
    chk("mid sys_adr", sys_adr, 32'hAAAA_5555);
    @(negedge clk);
    chk("mid xfer busy", {31'd0, busy}, 1);
    snap();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    free_bd = 8'd64;
    chk("mid rst busy", {31'd0, busy}, 0);
    chk("mid rst a_cmp", {31'd0, a_cmp}, 0);
    chk("mid rst sys_adr", sys_adr, 0);
    chk("mid rst blk_adr", blk_adr, 0);
    repeat (5) @(negedge clk);
    chk("mid rst no a_cmp", cnt_cmp - b_cmp, 0);
    chk("mid rst idle", {31'd0, busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
